// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: MULT/DIV/MADD/MSUB with MTHI/MTLO writes and cancel.
// Latency: MULT_LAT or DIV_LAT busy cycles; hi/lo and done update on the edge that ends busy.
// Backpressure: start is ignored while busy (Decode stalls upstream); cancel aborts without commit.
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;

    logic               mul_sgn, div_sgn, a_neg, b_neg;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc, res;
    logic [WIDTH-1:0]   a_mag, b_mag, divisor, q_mag, r_mag, quo, rem;

    assign acc = {hi, lo};

    // Signed divide runs on magnitudes; the min/-1 overflow case wraps to min with rem 0.
    always_comb begin
        mul_sgn = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
        div_sgn = (op_q == OP_DIV);
        a_ext   = mul_sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext   = mul_sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod    = a_ext * b_ext;
        a_neg   = div_sgn && a_q[WIDTH-1];
        b_neg   = div_sgn && b_q[WIDTH-1];
        a_mag   = a_neg ? -a_q : a_q;
        b_mag   = b_neg ? -b_q : b_q;
        divisor = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        quo     = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem     = a_neg ? -r_mag : r_mag;
        res     = acc;
        case (op_q)
            OP_MULT, OP_MULTU: res = prod;
            OP_MADD, OP_MADDU: res = acc + prod;
            OP_MSUB, OP_MSUBU: res = acc - prod;
            OP_DIV, OP_DIVU:   if (b_q != '0) res = {rem, quo};
            default:           res = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            hi   <= '0;
            lo   <= '0;
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                if (cancel) begin
                    busy <= 1'b0;
                    cnt  <= '0;
                end else if (cnt == CNT_W'(1)) begin
                    hi   <= res[2*WIDTH-1:WIDTH];
                    lo   <= res[WIDTH-1:0];
                    busy <= 1'b0;
                    cnt  <= '0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end else if (start && !cancel) begin
                if (op >= OP_MULT && op <= OP_MSUBU) begin
                    op_q <= op;
                    a_q  <= d1;
                    b_q  <= d2;
                    busy <= 1'b1;
                    cnt  <= (op == OP_DIV || op == OP_DIVU) ? DIV_CNT : MULT_CNT;
                end else if (op == OP_MTHI) begin
                    hi <= d1;
                end else if (op == OP_MTLO) begin
                    lo <= d1;
                end
            end
        end
    end

endmodule
